// File: rtl/matmul_seq_pkg.sv
// Shared types and helpers for the sequential matrix-multiply sequencer.
package matmul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  function automatic int addr_w(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-M up counter with enable, synchronous clear and terminal-count flag.
module mod_counter
  import matmul_seq_pkg::*;
#(
  parameter int M = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 en,
  output logic [addr_w(M)-1:0] count,
  output logic                 tc
);

  localparam int W = addr_w(M);
  localparam logic [W-1:0] LAST = W'(M - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clock) begin
    if (clear)   count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/matmul_seq.sv
// Address/control sequencer for C = A x B: one MAC per inner index,
// then a handshaked write of each C element, row-major.
module matmul_seq
  import matmul_seq_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int INNER = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  output logic [addr_w(ROWS*INNER)-1:0]   a_addr,
  output logic [addr_w(INNER*COLS)-1:0]   b_addr,
  output logic                            mac_en,
  output logic                            acc_clr,
  output logic [addr_w(ROWS*COLS)-1:0]    c_addr,
  output logic                            c_wr,
  input  logic                            c_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = addr_w(ROWS*INNER);
  localparam int BW = addr_w(INNER*COLS);
  localparam int CW = addr_w(ROWS*COLS);
  localparam int IW = addr_w(ROWS);
  localparam int JW = addr_w(COLS);
  localparam int KW = addr_w(INNER);

  state_t state;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic i_tc, j_tc, k_tc;
  logic clr, i_en, j_en, k_en;

  // Counters are parked at zero whenever no sequence is in flight.
  assign clr  = reset | abort | (state == IDLE) | (state == DONE);
  assign k_en = (state == MAC);
  assign j_en = (state == WRITE) & c_ready;
  assign i_en = j_en & j_tc;

  mod_counter #(.M(ROWS)) u_i (
    .clock (clock),
    .clear (clr),
    .en    (i_en),
    .count (i),
    .tc    (i_tc)
  );

  mod_counter #(.M(COLS)) u_j (
    .clock (clock),
    .clear (clr),
    .en    (j_en),
    .count (j),
    .tc    (j_tc)
  );

  mod_counter #(.M(INNER)) u_k (
    .clock (clock),
    .clear (clr),
    .en    (k_en),
    .count (k),
    .tc    (k_tc)
  );

  always_ff @(posedge clock) begin
    if (reset)      state <= IDLE;
    else if (abort) state <= IDLE;
    else begin
      unique case (state)
        IDLE:    if (start) state <= MAC;
        MAC:     if (k_tc) state <= WRITE;
        WRITE:   if (c_ready) state <= (i_tc && j_tc) ? DONE : MAC;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    mac_en  = 1'b0;
    acc_clr = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    c_wr    = 1'b0;
    c_addr  = '0;
    done    = 1'b0;
    unique case (state)
      MAC: begin
        mac_en  = 1'b1;
        acc_clr = (k == '0);
        a_addr  = AW'(i) * AW'(INNER) + AW'(k);
        b_addr  = BW'(k) * BW'(COLS) + BW'(j);
      end
      WRITE: begin
        c_wr   = 1'b1;
        c_addr = CW'(i) * CW'(COLS) + CW'(j);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq in 2x2x2, 1x1x1 and default configs.
module tb_matmul_seq;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic st = 1'b0;
  logic ab = 1'b0;
  logic rdy = 1'b1;
  int   sel = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    bit clr;
  } mac_t;

  mac_t mac_q[$];
  int   wr_q[$];

  always #5 clock = ~clock;

  logic       s0, s1, s2, b0, b1, b2, r0, r1, r2;
  logic [1:0] aa0, ba0, ca0;
  logic [0:0] aa1, ba1, ca1;
  logic [4:0] aa2, ba2;
  logic [3:0] ca2;
  logic       me0, ac0, cw0, by0, dn0;
  logic       me1, ac1, cw1, by1, dn1;
  logic       me2, ac2, cw2, by2, dn2;

  assign s0 = st && sel == 0;
  assign s1 = st && sel == 1;
  assign s2 = st && sel == 2;
  assign b0 = ab && sel == 0;
  assign b1 = ab && sel == 1;
  assign b2 = ab && sel == 2;
  assign r0 = (sel == 0) ? rdy : 1'b1;
  assign r1 = (sel == 1) ? rdy : 1'b1;
  assign r2 = (sel == 2) ? rdy : 1'b1;

  matmul_seq #(.ROWS(2), .COLS(2), .INNER(2)) u0 (
    .clock(clock), .reset(reset), .start(s0), .abort(b0),
    .a_addr(aa0), .b_addr(ba0), .mac_en(me0), .acc_clr(ac0),
    .c_addr(ca0), .c_wr(cw0), .c_ready(r0), .busy(by0), .done(dn0)
  );

  matmul_seq #(.ROWS(1), .COLS(1), .INNER(1)) u1 (
    .clock(clock), .reset(reset), .start(s1), .abort(b1),
    .a_addr(aa1), .b_addr(ba1), .mac_en(me1), .acc_clr(ac1),
    .c_addr(ca1), .c_wr(cw1), .c_ready(r1), .busy(by1), .done(dn1)
  );

  matmul_seq u2 (
    .clock(clock), .reset(reset), .start(s2), .abort(b2),
    .a_addr(aa2), .b_addr(ba2), .mac_en(me2), .acc_clr(ac2),
    .c_addr(ca2), .c_wr(cw2), .c_ready(r2), .busy(by2), .done(dn2)
  );

  int o_a, o_b, o_c;
  logic o_mac, o_clr, o_wr, o_busy, o_done;

  always_comb begin
    o_a = 0; o_b = 0; o_c = 0;
    o_mac = 1'b0; o_clr = 1'b0; o_wr = 1'b0;
    o_busy = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin
        o_a = int'(aa0); o_b = int'(ba0); o_c = int'(ca0);
        o_mac = me0; o_clr = ac0; o_wr = cw0; o_busy = by0; o_done = dn0;
      end
      1: begin
        o_a = int'(aa1); o_b = int'(ba1); o_c = int'(ca1);
        o_mac = me1; o_clr = ac1; o_wr = cw1; o_busy = by1; o_done = dn1;
      end
      default: begin
        o_a = int'(aa2); o_b = int'(ba2); o_c = int'(ca2);
        o_mac = me2; o_clr = ac2; o_wr = cw2; o_busy = by2; o_done = dn2;
      end
    endcase
  end

  task automatic idle_outputs(input string name);
    checks++;
    if (o_a !== 0 || o_b !== 0 || o_c !== 0 || o_mac !== 1'b0 ||
        o_clr !== 1'b0 || o_wr !== 1'b0 || o_busy !== 1'b0 ||
        o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s sel=%0d got a=%0d b=%0d c=%0d mac=%b clr=%b wr=%b busy=%b done=%b want all 0",
               name, sel, o_a, o_b, o_c, o_mac, o_clr, o_wr, o_busy, o_done);
    end
  endtask

  // One full sequence with expectations queued up front and drained as the DUT emits them.
  task automatic run(input int r, input int c, input int n, input int stall_addr,
                     input int stall_n, input int exp_done, input bit poke);
    int cyc, stalled, hold;
    bit seen;
    mac_t m, e;
    int ew;
    stalled = 0; hold = 0; seen = 0;
    mac_q.delete();
    wr_q.delete();
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        for (int k = 0; k < n; k++) begin
          m.a = i * n + k; m.b = k * c + j; m.clr = (k == 0);
          mac_q.push_back(m);
        end
        wr_q.push_back(i * c + j);
      end
    @(negedge clock); st = 1'b1; rdy = 1'b1;
    @(posedge clock); #1; st = 1'b0; cyc = 1;
    while (cyc <= exp_done + 20 && !seen) begin
      rdy = 1'b1;
      if (o_wr && o_c == stall_addr) begin
        hold++;
        if (stalled < stall_n) begin rdy = 1'b0; stalled++; end
      end
      if (poke) st = (cyc == 4 || cyc == exp_done);
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_run cyc=%0d got %b want 1", cyc, o_busy);
      end
      checks++;
      if (o_mac) begin
        if (mac_q.size() == 0) begin
          errors++;
          $display("FAIL mac_extra cyc=%0d got mac_en=1 want 0", cyc);
        end else begin
          e = mac_q.pop_front();
          if (o_a !== e.a || o_b !== e.b || o_clr !== e.clr) begin
            errors++;
            $display("FAIL mac cyc=%0d got a=%0d b=%0d clr=%b want a=%0d b=%0d clr=%b",
                     cyc, o_a, o_b, o_clr, e.a, e.b, e.clr);
          end
        end
      end else if (o_a !== 0 || o_b !== 0 || o_clr !== 1'b0) begin
        errors++;
        $display("FAIL mac_idle cyc=%0d got a=%0d b=%0d clr=%b want 0", cyc, o_a, o_b, o_clr);
      end
      checks++;
      if (o_wr) begin
        if (rdy) begin
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_extra cyc=%0d got c=%0d want none", cyc, o_c);
          end else begin
            ew = wr_q.pop_front();
            if (o_c !== ew) begin
              errors++;
              $display("FAIL wr cyc=%0d got c=%0d want %0d", cyc, o_c, ew);
            end
          end
        end
      end else if (o_c !== 0) begin
        errors++;
        $display("FAIL c_idle cyc=%0d got c=%0d want 0", cyc, o_c);
      end
      if (o_done) begin
        seen = 1;
        checks++;
        if (cyc !== exp_done) begin
          errors++;
          $display("FAIL done_cycle got %0d want %0d", cyc, exp_done);
        end
      end else begin
        @(posedge clock); #1; cyc++;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got none want cycle %0d", exp_done);
    end
    checks++;
    if (mac_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got mac=%0d wr=%0d want 0 0", mac_q.size(), wr_q.size());
    end
    if (stall_n > 0) begin
      checks++;
      if (hold !== stall_n + 1) begin
        errors++;
        $display("FAIL wr_hold got %0d want %0d", hold, stall_n + 1);
      end
    end
    @(posedge clock); #1; st = 1'b0; rdy = 1'b1;
    idle_outputs("after_done");
    @(posedge clock); #1;
    idle_outputs("after_done2");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      idle_outputs("reset");
    end
    reset = 1'b0;
    sel = 0;
  endtask

  task automatic test_basic();
    sel = 0;
    run(2, 2, 2, -1, 0, 13, 0);
  endtask

  task automatic test_stall();
    sel = 0;
    run(2, 2, 2, 1, 3, 16, 0);
  endtask

  task automatic test_unit();
    sel = 1;
    run(1, 1, 1, -1, 0, 3, 0);
  endtask

  task automatic test_abort();
    sel = 2;
    @(negedge clock); st = 1'b1;
    @(posedge clock); #1; st = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    checks++;
    if (o_mac !== 1'b1 || o_a !== 4) begin
      errors++;
      $display("FAIL abort_pre got mac=%b a=%0d want 1 4", o_mac, o_a);
    end
    ab = 1'b1;
    @(posedge clock); #1; ab = 1'b0;
    idle_outputs("abort_idle");
    repeat (4) begin
      @(posedge clock); #1;
      idle_outputs("abort_quiet");
    end
    run(4, 4, 8, -1, 0, 145, 0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    run(2, 2, 2, -1, 0, 13, 1);
    @(negedge clock); st = 1'b1; ab = 1'b1;
    @(posedge clock); #1; st = 1'b0; ab = 1'b0;
    idle_outputs("abort_start_idle");
    @(posedge clock); #1;
    idle_outputs("abort_start_idle2");
    run(2, 2, 2, -1, 0, 13, 0);
  endtask

  task automatic test_reset_write();
    int n;
    sel = 0;
    @(negedge clock); st = 1'b1;
    @(posedge clock); #1; st = 1'b0; rdy = 1'b0;
    n = 0;
    while (!o_wr && n < 10) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (o_wr !== 1'b1) begin
      errors++;
      $display("FAIL reach_write got c_wr=%b want 1", o_wr);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0; rdy = 1'b1;
    idle_outputs("reset_in_write");
    run(2, 2, 2, -1, 0, 13, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_unit();
    test_abort();
    test_back_to_back();
    test_reset_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter ROWS, default 4, SHALL set the number of rows of A and C (minimum 1).
REQ-002 Parameter COLS, default 4, SHALL set the number of columns of B and C (minimum 1).
REQ-003 Parameter INNER, default 8, SHALL set the number of columns of A and rows of B, i.e. MACs per C element (minimum 1).
REQ-004 clock  in  1  clock; all logic SHALL be sensitive to the rising edge only.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  sampled only in IDLE; begins one full C = A x B sequence.
REQ-007 abort  in  1  synchronous cancel of a running sequence.
REQ-008 a_addr  out  AW  A read address; AW = max(1, clog2(ROWS*INNER)).
REQ-009 b_addr  out  BW  B read address; BW = max(1, clog2(INNER*COLS)).
REQ-010 mac_en  out  1  datapath multiply-accumulate enable.
REQ-011 acc_clr  out  1  accumulator load-instead-of-add, qualifies the first MAC of an element.
REQ-012 c_addr  out  CW  C write address; CW = max(1, clog2(ROWS*COLS)).
REQ-013 c_wr  out  1  C write request.
REQ-014 c_ready  in  1  C write accept; a write completes in a cycle with c_wr=1 and c_ready=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, MAC, WRITE and DONE; all outputs SHALL be registered or decoded from registered state and counters only.
REQ-018 IDLE: when start=1 and abort=0, the next state SHALL be MAC with i=j=k=0; otherwise the FSM SHALL remain in IDLE.
REQ-019 MAC: mac_en=1, acc_clr=(k==0), a_addr=i*INNER+k, b_addr=k*COLS+j; k SHALL increment each cycle; after the cycle with k=INNER-1, the next state SHALL be WRITE with k=0.
REQ-020 WRITE: c_wr=1 and c_addr=i*COLS+j SHALL be held stable until c_ready=1; in the completing cycle, j SHALL advance, or wrap to 0 with i incrementing when j=COLS-1.
REQ-021 WRITE completion on element (ROWS-1, COLS-1) SHALL go to DONE; any other completion SHALL go to MAC.
REQ-022 DONE SHALL last one cycle with done=1 and SHALL then go to IDLE; start in DONE SHALL be ignored.
REQ-023 Outside their own states, mac_en, acc_clr, c_wr and done SHALL be 0, and the address outputs SHALL be 0.
REQ-024 With c_ready tied high, done SHALL assert exactly ROWS*COLS*(INNER+1)+1 cycles after the edge at which start was sampled.
REQ-025 start while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-026 abort=1 in MAC, WRITE or DONE SHALL force IDLE on the next edge with i=j=k=0; done SHALL NOT pulse, and a pending write SHALL be dropped.
REQ-027 abort=1 with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-028 All counter arithmetic SHALL be unsigned, sized to its parameter, and wrap exactly at its terminal count, never at a power of two.

Reset
REQ-029 reset=1 SHALL force IDLE with i=j=k=0, and every output 0 on the following cycle, regardless of state.
REQ-030 reset SHALL take priority over abort and start.

Structure
REQ-031 Package matmul_seq_pkg SHALL hold the state enumeration and the address-width helper function (max(1, clog2(x))).
REQ-032 One sub-module, mod_counter (parametrised modulus, enable, synchronous clear, terminal-count flag), SHALL be instantiated for each of i, j and k.

Verification
REQ-033 ROWS=COLS=INNER=2, c_ready=1, start pulse -> a_addr sequence 0,1,0,1,2,3,2,3; b_addr sequence 0,2,1,3,0,2,1,3; c_addr 0,1,2,3; done at cycle 13.
REQ-034 Same config, c_ready held low for 3 cycles on the first write of c_addr=1 -> c_wr and c_addr=1 held for 4 cycles; done at cycle 16.
REQ-035 ROWS=COLS=INNER=1 -> acc_clr=1 with mac_en for one cycle, then one write with c_addr=0; done at cycle 3.
REQ-036 Default config, abort in the 5th MAC cycle -> IDLE next cycle, busy=0, no done; a subsequent start yields a full run with done at cycle 145.
REQ-037 start pulsed while busy, plus abort+start together in IDLE -> no effect on the sequence, the run count, or the FSM state.
REQ-038 reset asserted in WRITE with c_ready=0 -> all outputs 0 the next cycle; the FSM is in IDLE.
